// File: rtl/reg_bank_arb_pkg.sv
// Shared types and constants for the configuration register bank arbiter.
package reg_bank_arb_pkg;

    // Width of the optional simultaneous-request counter.
    localparam int CONFLICT_CNT_W = 8;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Requester identity; also the encoding of the round-robin last_grant.
    typedef enum logic {
        REQ_SPI = 1'b0,
        REQ_I2C = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick between the SPI and I2C requesters.
// A lone requester wins outright; on a tie the one not granted last wins.
module rr_arbiter2
    import reg_bank_arb_pkg::*;
(
    input  logic i_req_spi,
    input  logic i_req_i2c,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_valid
);

    req_id_t w_last_grant;
    req_id_t w_grant;

    assign w_last_grant = req_id_t'(i_last_grant);

    // Select the winner from the current request levels and the last grant.
    always_comb begin
        // NOTE: default every combinational output first so no path can infer a latch.
        w_grant = REQ_SPI;
        if (i_req_spi && i_req_i2c) begin
            w_grant = (w_last_grant == REQ_I2C) ? REQ_SPI : REQ_I2C;
        end else if (i_req_i2c) begin
            w_grant = REQ_I2C;
        end
    end

    assign o_grant = w_grant;
    assign o_valid = i_req_spi | i_req_i2c;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Serialises SPI and I2C register transactions onto the single-port
// configuration register bank: IDLE -> ACCESS (bank strobe) -> DONE (ack).
// Optional feature macro: ARB_CONFLICT_CNT_EN adds the conflict_cnt port and
// its saturating count of IDLE cycles with both requests high.
module reg_bank_arbiter
    import reg_bank_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_req,
    input  logic                      spi_we,
    input  logic [ADDR_WIDTH-1:0]     spi_addr,
    input  logic [DATA_WIDTH-1:0]     spi_wdata,
    output logic                      spi_ack,
    output logic [DATA_WIDTH-1:0]     spi_rdata,
    input  logic                      i2c_req,
    input  logic                      i2c_we,
    input  logic [ADDR_WIDTH-1:0]     i2c_addr,
    input  logic [DATA_WIDTH-1:0]     i2c_wdata,
    output logic                      i2c_ack,
    output logic [DATA_WIDTH-1:0]     i2c_rdata,
    output logic                      bank_en,
    output logic                      bank_we,
    output logic [ADDR_WIDTH-1:0]     bank_addr,
    output logic [DATA_WIDTH-1:0]     bank_wdata,
    input  logic [DATA_WIDTH-1:0]     bank_rdata,
    output logic                      busy
`ifdef ARB_CONFLICT_CNT_EN
    ,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);

    state_t                  r_state;
    req_id_t                 r_id;
    req_id_t                 r_last_grant;
    logic                    r_we;
    logic                    r_bank_en;
    logic                    r_bank_we;
    logic [ADDR_WIDTH-1:0]   r_bank_addr;
    logic [DATA_WIDTH-1:0]   r_bank_wdata;
    logic                    r_spi_ack;
    logic                    r_i2c_ack;
    logic [DATA_WIDTH-1:0]   r_spi_rdata;
    logic [DATA_WIDTH-1:0]   r_i2c_rdata;
    logic                    r_busy;

    logic                    w_grant;
    logic                    w_valid;
    req_id_t                 w_grant_id;
    logic                    w_sel_we;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;

    rr_arbiter2 u_rr_arbiter2 (
        .i_req_spi    (spi_req),
        .i_req_i2c    (i2c_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_valid      (w_valid)
    );

    assign w_grant_id  = req_id_t'(w_grant);
    assign w_sel_we    = (w_grant_id == REQ_I2C) ? i2c_we    : spi_we;
    assign w_sel_addr  = (w_grant_id == REQ_I2C) ? i2c_addr  : spi_addr;
    assign w_sel_wdata = (w_grant_id == REQ_I2C) ? i2c_wdata : spi_wdata;

    // Transaction sequencer with registered bank strobes, acks and read data.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments; reset is synchronous.
        if (rst) begin
            r_state      <= IDLE;
            r_id         <= REQ_SPI;
            r_last_grant <= REQ_I2C;
            r_we         <= 1'b0;
            r_bank_en    <= 1'b0;
            r_bank_we    <= 1'b0;
            r_bank_addr  <= '0;
            r_bank_wdata <= '0;
            r_spi_ack    <= 1'b0;
            r_i2c_ack    <= 1'b0;
            r_spi_rdata  <= '0;
            r_i2c_rdata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_we         <= w_sel_we;
                        r_bank_en    <= 1'b1;
                        r_bank_we    <= w_sel_we;
                        r_bank_addr  <= w_sel_addr;
                        r_bank_wdata <= w_sel_wdata;
                        r_busy       <= 1'b1;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_bank_en <= 1'b0;
                    r_bank_we <= 1'b0;
                    if (r_id == REQ_SPI) begin
                        r_spi_ack <= 1'b1;
                    end else begin
                        r_i2c_ack <= 1'b1;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    r_spi_ack <= 1'b0;
                    r_i2c_ack <= 1'b0;
                    if (!r_we) begin
                        if (r_id == REQ_SPI) begin
                            r_spi_rdata <= bank_rdata;
                        end else begin
                            r_i2c_rdata <= bank_rdata;
                        end
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_CONFLICT_CNT_EN
    logic [CONFLICT_CNT_W-1:0] r_conflict_cnt;

    // Count IDLE cycles with both requests high, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if ((r_state == IDLE) && spi_req && i2c_req && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + CONFLICT_CNT_W'(1);
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

    // Bank read data only becomes valid in the DONE cycle, so the winner's
    // rdata bypasses the holding register while its read ack is high; the
    // register captures the same value as DONE ends and holds it afterwards.
    assign spi_rdata  = (r_spi_ack && !r_we) ? bank_rdata : r_spi_rdata;
    assign i2c_rdata  = (r_i2c_ack && !r_we) ? bank_rdata : r_i2c_rdata;

    assign spi_ack    = r_spi_ack;
    assign i2c_ack    = r_i2c_ack;
    assign bank_en    = r_bank_en;
    assign bank_we    = r_bank_we;
    assign bank_addr  = r_bank_addr;
    assign bank_wdata = r_bank_wdata;
    assign busy       = r_busy;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed testbench for reg_bank_arbiter with a small register bank model.
// Build with ARB_CONFLICT_CNT_EN defined to also cover conflict_cnt.
module tb_reg_bank_arbiter;

    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          spi_req, spi_we, i2c_req, i2c_we;
    logic [AW-1:0] spi_addr, i2c_addr;
    logic [DW-1:0] spi_wdata, i2c_wdata;
    logic          spi_ack, i2c_ack;
    logic [DW-1:0] spi_rdata, i2c_rdata;
    logic          bank_en, bank_we, busy;
    logic [AW-1:0] bank_addr;
    logic [DW-1:0] bank_wdata;
    logic [DW-1:0] bank_rdata = '0;
`ifdef ARB_CONFLICT_CNT_EN
    logic [7:0]    conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [8];

    always #5 clk = ~clk;

    reg_bank_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_req    (spi_req),
        .spi_we     (spi_we),
        .spi_addr   (spi_addr),
        .spi_wdata  (spi_wdata),
        .spi_ack    (spi_ack),
        .spi_rdata  (spi_rdata),
        .i2c_req    (i2c_req),
        .i2c_we     (i2c_we),
        .i2c_addr   (i2c_addr),
        .i2c_wdata  (i2c_wdata),
        .i2c_ack    (i2c_ack),
        .i2c_rdata  (i2c_rdata),
        .bank_en    (bank_en),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata),
        .busy       (busy)
`ifdef ARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Register bank: synchronous write, read data registered one cycle after bank_en.
    always @(posedge clk) begin
        if (bank_en) begin
            if (bank_we) mem[bank_addr] <= bank_wdata;
            bank_rdata <= mem[bank_addr];
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        spi_req = 0; spi_we = 0; spi_addr = '0; spi_wdata = '0;
        i2c_req = 0; i2c_we = 0; i2c_addr = '0; i2c_wdata = '0;
        repeat (2) @(negedge clk);
        checks++; if (spi_ack !== 1'b0)    begin errors++; $display("FAIL rst_spi_ack: got %b want 0", spi_ack); end
        checks++; if (i2c_ack !== 1'b0)    begin errors++; $display("FAIL rst_i2c_ack: got %b want 0", i2c_ack); end
        checks++; if (bank_en !== 1'b0)    begin errors++; $display("FAIL rst_bank_en: got %b want 0", bank_en); end
        checks++; if (bank_we !== 1'b0)    begin errors++; $display("FAIL rst_bank_we: got %b want 0", bank_we); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (bank_addr !== 3'd0)  begin errors++; $display("FAIL rst_bank_addr: got %h want 0", bank_addr); end
        checks++; if (bank_wdata !== 8'h0) begin errors++; $display("FAIL rst_bank_wdata: got %h want 00", bank_wdata); end
        checks++; if (spi_rdata !== 8'h0)  begin errors++; $display("FAIL rst_spi_rdata: got %h want 00", spi_rdata); end
        checks++; if (i2c_rdata !== 8'h0)  begin errors++; $display("FAIL rst_i2c_rdata: got %h want 00", i2c_rdata); end
`ifdef ARB_CONFLICT_CNT_EN
        checks++; if (conflict_cnt !== 8'd0) begin errors++; $display("FAIL rst_conflict_cnt: got %0d want 0", conflict_cnt); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_spi_write_read;
        // Write 0xA5 to address 3.
        spi_req = 1; spi_we = 1; spi_addr = 3'd3; spi_wdata = 8'hA5;
        @(negedge clk);
        checks++; if (bank_en !== 1'b1)    begin errors++; $display("FAIL wr_bank_en: got %b want 1", bank_en); end
        checks++; if (bank_we !== 1'b1)    begin errors++; $display("FAIL wr_bank_we: got %b want 1", bank_we); end
        checks++; if (bank_addr !== 3'd3)  begin errors++; $display("FAIL wr_bank_addr: got %h want 3", bank_addr); end
        checks++; if (bank_wdata !== 8'hA5) begin errors++; $display("FAIL wr_bank_wdata: got %h want a5", bank_wdata); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
        checks++; if (spi_ack !== 1'b0)    begin errors++; $display("FAIL wr_early_ack: got %b want 0", spi_ack); end
        @(negedge clk);
        checks++; if (spi_ack !== 1'b1)    begin errors++; $display("FAIL wr_spi_ack: got %b want 1", spi_ack); end
        checks++; if (bank_en !== 1'b0)    begin errors++; $display("FAIL wr_bank_en_pulse: got %b want 0", bank_en); end
        checks++; if (spi_rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata_untouched: got %h want 00", spi_rdata); end
        checks++; if (mem[3] !== 8'hA5)    begin errors++; $display("FAIL wr_bank_content: got %h want a5", mem[3]); end
        spi_req = 0;
        @(negedge clk);
        checks++; if (spi_ack !== 1'b0)    begin errors++; $display("FAIL wr_ack_width: got %b want 0", spi_ack); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL wr_busy_end: got %b want 0", busy); end
        // Read back address 3.
        spi_req = 1; spi_we = 0; spi_addr = 3'd3; spi_wdata = 8'h00;
        @(negedge clk);
        checks++; if (bank_en !== 1'b1 || bank_we !== 1'b0) begin errors++; $display("FAIL rd_bank_strobe: got en=%b we=%b want en=1 we=0", bank_en, bank_we); end
        @(negedge clk);
        checks++; if (spi_ack !== 1'b1)    begin errors++; $display("FAIL rd_spi_ack: got %b want 1", spi_ack); end
        checks++; if (spi_rdata !== 8'hA5) begin errors++; $display("FAIL rd_spi_rdata: got %h want a5", spi_rdata); end
        checks++; if (i2c_ack !== 1'b0)    begin errors++; $display("FAIL rd_i2c_ack: got %b want 0", i2c_ack); end
        spi_req = 0;
        @(negedge clk);
        checks++; if (spi_rdata !== 8'hA5) begin errors++; $display("FAIL rd_spi_rdata_hold: got %h want a5", spi_rdata); end
    endtask

    task automatic test_i2c_read;
        i2c_req = 1; i2c_we = 0; i2c_addr = 3'd5;
        @(negedge clk);
        checks++; if (bank_addr !== 3'd5)  begin errors++; $display("FAIL i2c_bank_addr: got %h want 5", bank_addr); end
        checks++; if (i2c_ack !== 1'b0)    begin errors++; $display("FAIL i2c_early_ack: got %b want 0", i2c_ack); end
        @(negedge clk);
        checks++; if (i2c_ack !== 1'b1)    begin errors++; $display("FAIL i2c_ack: got %b want 1", i2c_ack); end
        checks++; if (i2c_rdata !== 8'h15) begin errors++; $display("FAIL i2c_rdata: got %h want 15", i2c_rdata); end
        checks++; if (spi_ack !== 1'b0)    begin errors++; $display("FAIL i2c_spi_ack: got %b want 0", spi_ack); end
        checks++; if (spi_rdata !== 8'hA5) begin errors++; $display("FAIL i2c_spi_rdata_kept: got %h want a5", spi_rdata); end
        i2c_req = 0;
        @(negedge clk);
        checks++; if (i2c_rdata !== 8'h15) begin errors++; $display("FAIL i2c_rdata_hold: got %h want 15", i2c_rdata); end
        checks++; if (i2c_ack !== 1'b0)    begin errors++; $display("FAIL i2c_ack_width: got %b want 0", i2c_ack); end
    endtask

    task automatic test_simultaneous;
        // First tie after reset: SPI wins.
        spi_req = 1; spi_we = 0; spi_addr = 3'd1;
        i2c_req = 1; i2c_we = 0; i2c_addr = 3'd2;
        @(negedge clk);
        checks++; if (bank_addr !== 3'd1)  begin errors++; $display("FAIL tie1_bank_addr: got %h want 1", bank_addr); end
        @(negedge clk);
        checks++; if (spi_ack !== 1'b1 || i2c_ack !== 1'b0) begin errors++; $display("FAIL tie1_ack: got spi=%b i2c=%b want spi=1 i2c=0", spi_ack, i2c_ack); end
        checks++; if (spi_rdata !== 8'h11) begin errors++; $display("FAIL tie1_spi_rdata: got %h want 11", spi_rdata); end
        // SPI immediately issues another read, so the next IDLE is a second tie.
        spi_addr = 3'd4;
        @(negedge clk);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL tie_idle_busy: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (bank_addr !== 3'd2)  begin errors++; $display("FAIL tie2_bank_addr: got %h want 2", bank_addr); end
        @(negedge clk);
        checks++; if (i2c_ack !== 1'b1 || spi_ack !== 1'b0) begin errors++; $display("FAIL tie2_ack: got spi=%b i2c=%b want spi=0 i2c=1", spi_ack, i2c_ack); end
        checks++; if (i2c_rdata !== 8'h12) begin errors++; $display("FAIL tie2_i2c_rdata: got %h want 12", i2c_rdata); end
        checks++; if (spi_rdata !== 8'h11) begin errors++; $display("FAIL tie2_spi_rdata_kept: got %h want 11", spi_rdata); end
        i2c_req = 0;
        repeat (2) @(negedge clk);
        checks++; if (bank_addr !== 3'd4 || bank_en !== 1'b1) begin errors++; $display("FAIL pend_bank: got addr=%h en=%b want addr=4 en=1", bank_addr, bank_en); end
        @(negedge clk);
        checks++; if (spi_ack !== 1'b1)    begin errors++; $display("FAIL pend_spi_ack: got %b want 1", spi_ack); end
        checks++; if (spi_rdata !== 8'h14) begin errors++; $display("FAIL pend_spi_rdata: got %h want 14", spi_rdata); end
        checks++; if (i2c_rdata !== 8'h12) begin errors++; $display("FAIL pend_i2c_rdata_kept: got %h want 12", i2c_rdata); end
        spi_req = 0;
        @(negedge clk);
`ifdef ARB_CONFLICT_CNT_EN
        checks++; if (conflict_cnt !== 8'd2) begin errors++; $display("FAIL tie_conflict_cnt: got %0d want 2", conflict_cnt); end
`endif
    endtask

    task automatic test_back_to_back;
        int   spi_left, i2c_left, n_acks;
        logic prev_en, prev_sa, prev_ia;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        spi_left = 3; i2c_left = 3; n_acks = 0;
        prev_en = 0; prev_sa = 0; prev_ia = 0;
        spi_req = 1; spi_we = 1; spi_addr = 3'd0; spi_wdata = 8'h40;
        i2c_req = 1; i2c_we = 1; i2c_addr = 3'd7; i2c_wdata = 8'h70;
        for (int cyc = 0; cyc < 60 && n_acks < 6; cyc++) begin
            @(negedge clk);
            checks++; if (bank_en && prev_en) begin errors++; $display("FAIL b2b_bank_en_consec: got 1 twice want single pulse (cycle %0d)", cyc); end
            checks++; if ((spi_ack && prev_sa) || (i2c_ack && prev_ia)) begin errors++; $display("FAIL b2b_ack_width: got ack high two cycles want one (cycle %0d)", cyc); end
            prev_en = bank_en; prev_sa = spi_ack; prev_ia = i2c_ack;
            if (spi_ack) begin
                checks++; if ((n_acks % 2) != 0 || i2c_ack) begin errors++; $display("FAIL b2b_order: got SPI at grant %0d want I2C", n_acks); end
                n_acks++; spi_left--;
                if (spi_left == 0) spi_req = 0; else spi_wdata = spi_wdata + 8'h01;
            end else if (i2c_ack) begin
                checks++; if ((n_acks % 2) != 1) begin errors++; $display("FAIL b2b_order: got I2C at grant %0d want SPI", n_acks); end
                n_acks++; i2c_left--;
                if (i2c_left == 0) i2c_req = 0; else i2c_wdata = i2c_wdata + 8'h01;
            end
        end
        checks++; if (n_acks != 6) begin errors++; $display("FAIL b2b_timeout: got %0d acks want 6", n_acks); end
        spi_req = 0; i2c_req = 0;
        @(negedge clk);
        checks++; if (spi_ack !== 1'b0 || i2c_ack !== 1'b0) begin errors++; $display("FAIL b2b_last_ack_width: got spi=%b i2c=%b want 0 0", spi_ack, i2c_ack); end
        checks++; if (mem[0] !== 8'h42 || mem[7] !== 8'h72) begin errors++; $display("FAIL b2b_bank_content: got %h/%h want 42/72", mem[0], mem[7]); end
`ifdef ARB_CONFLICT_CNT_EN
        checks++; if (conflict_cnt !== 8'd5) begin errors++; $display("FAIL b2b_conflict_cnt: got %0d want 5", conflict_cnt); end
`endif
    endtask

    task automatic test_reset_mid;
        spi_req = 1; spi_we = 0; spi_addr = 3'd3;
        @(negedge clk);
        checks++; if (bank_en !== 1'b1) begin errors++; $display("FAIL rmid_in_access: got bank_en=%b want 1", bank_en); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (spi_ack !== 1'b0)   begin errors++; $display("FAIL rmid_no_ack: got %b want 0", spi_ack); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (spi_rdata !== 8'h0) begin errors++; $display("FAIL rmid_spi_rdata: got %h want 00", spi_rdata); end
        checks++; if (i2c_rdata !== 8'h0) begin errors++; $display("FAIL rmid_i2c_rdata: got %h want 00", i2c_rdata); end
`ifdef ARB_CONFLICT_CNT_EN
        checks++; if (conflict_cnt !== 8'd0) begin errors++; $display("FAIL rmid_conflict_cnt: got %0d want 0", conflict_cnt); end
`endif
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bank_en !== 1'b1 || spi_ack !== 1'b0) begin errors++; $display("FAIL rmid_retry_access: got en=%b ack=%b want en=1 ack=0", bank_en, spi_ack); end
        @(negedge clk);
        checks++; if (spi_ack !== 1'b1)    begin errors++; $display("FAIL rmid_retry_ack: got %b want 1", spi_ack); end
        checks++; if (spi_rdata !== 8'hA5) begin errors++; $display("FAIL rmid_retry_rdata: got %h want a5", spi_rdata); end
        spi_req = 0;
        @(negedge clk);
    endtask

`ifdef ARB_CONFLICT_CNT_EN
    task automatic test_saturation;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        spi_req = 1; spi_we = 0; spi_addr = 3'd1;
        i2c_req = 1; i2c_we = 0; i2c_addr = 3'd2;
        repeat (300) @(negedge clk);
        checks++; if (conflict_cnt !== 8'd100) begin errors++; $display("FAIL sat_mid_count: got %0d want 100", conflict_cnt); end
        repeat (700) @(negedge clk);
        spi_req = 0; i2c_req = 0;
        repeat (4) @(negedge clk);
        checks++; if (conflict_cnt !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", conflict_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sat_drain_busy: got %b want 0", busy); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        test_reset();
        test_spi_write_read();
        test_i2c_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
`ifdef ARB_CONFLICT_CNT_EN
        test_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Two-requester arbiter sharing the single-port configuration register bank between the SPI slave and the I2C slave front ends. Each front end issues one read or write at a time over a req/ack handshake. The arbiter serialises these transactions onto the bank port with round-robin priority and returns read data to the winning requester. It sits between both serial front ends and the register bank inside the top-level user project.

## Interface
Parameters:
- ADDR_WIDTH, 3, register address width
- DATA_WIDTH, 8, register data width

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- spi_req  in  1  SPI transaction request (level)
- spi_we  in  1  1 = write, 0 = read
- spi_addr  in  ADDR_WIDTH  register address
- spi_wdata  in  DATA_WIDTH  write data
- spi_ack  out  1  one-cycle completion pulse
- spi_rdata  out  DATA_WIDTH  read data, valid from the ack cycle until the next SPI read completes
- i2c_req, i2c_we, i2c_addr, i2c_wdata, i2c_ack, i2c_rdata  same as the SPI set, for the I2C front end
- bank_en  out  1  bank access strobe, one cycle per transaction
- bank_we  out  1  bank write enable, qualified by bank_en
- bank_addr  out  ADDR_WIDTH  bank address
- bank_wdata  out  DATA_WIDTH  bank write data
- bank_rdata  in  DATA_WIDTH  bank read data, valid one cycle after bank_en
- busy  out  1  high in any state other than IDLE
- conflict_cnt  out  8  saturating count of simultaneous requests; present only with ARB_CONFLICT_CNT_EN

## Operation
- FSM states:
  - IDLE: if any req is high, pick the winner, latch its we/addr/wdata and id, then go to ACCESS.
  - ACCESS: bank_en=1, with bank_we/addr/wdata driven from the latched values; go to DONE.
  - DONE: pulse the winner's ack; on a read, load bank_rdata into the winner's rdata register; go to IDLE.
- Arbitration:
  - A single requester wins immediately.
  - When both request in IDLE, the requester that was not granted last wins.
  - last_grant resets to I2C, so SPI wins the first tie.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack is sampled high.
  - Deassert req on the edge that samples ack.
  - req must not depend combinationally on ack.
- Req inputs are ignored in ACCESS and DONE. A pending req from the loser stays high and is served on the next IDLE cycle.
- Writes never modify the rdata registers. The loser's rdata is never modified.
- No transaction is ever dropped except on reset.

## Timing
- Reset values: spi_ack, i2c_ack, bank_en, bank_we, busy = 0; bank_addr, bank_wdata, spi_rdata, i2c_rdata = 0; conflict_cnt = 0; state = IDLE.
- Latency: req sampled high in IDLE at edge N → bank_en high in cycle N+1 → ack high in cycle N+2.
- Throughput: one transaction per 3 cycles. Under back-to-back contention, grants alternate SPI, I2C, SPI, ...
- rdata updates on the same edge that raises ack.
- Reset mid-operation:
  - State returns to IDLE on the next edge, and no ack is issued.
  - A write whose bank_en was already sampled by the bank completes in the bank.
  - A reset asserted during IDLE or ACCESS leaves last_grant reset to I2C.
- bank_en is never high in two consecutive cycles.

## Configuration
- ARB_CONFLICT_CNT_EN defined:
  - conflict_cnt port and its 8-bit counter exist.
  - The counter increments by 1 for each IDLE cycle in which both spi_req and i2c_req are high.
  - It saturates at 255 and clears only on reset.
- ARB_CONFLICT_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package reg_bank_arb_pkg holds:
  - state enum (IDLE, ACCESS, DONE)
  - requester id enum (REQ_SPI, REQ_I2C)
  - constant CONFLICT_CNT_W = 8
- Sub-module rr_arbiter2 is the combinational two-way round-robin pick (inputs: two reqs, last_grant; outputs: grant id, valid). last_grant is registered in the parent and updated on entry to ACCESS.

## Test plan
- SPI write addr 3, data 0xA5, then SPI read addr 3 → bank_en pulses at N+1 with bank_we=1 for the write; read gives spi_ack at N+2 and spi_rdata = 0xA5.
- I2C read only → i2c_ack at N+2 with i2c_rdata equal to the bank content; spi_rdata unchanged; spi_ack stays 0.
- Both req in the same cycle after reset → SPI served first (ack at N+2), then I2C (ack at N+5). A second simultaneous pair → I2C first. conflict_cnt = 2 when the macro is defined.
- Both requesters hold req continuously for 6 transactions → grants alternate, bank_en never high in consecutive cycles, each ack is exactly one cycle wide.
- rst asserted in ACCESS during an SPI read → no spi_ack, busy = 0 the cycle after reset, spi_rdata = 0, next request serviced normally.
- Saturation, macro defined → 300 simultaneous-request events give conflict_cnt = 255. Macro undefined → build has no conflict_cnt port and behaviour is otherwise identical.
